// File: rtl/reset_period_monitor.sv
// Receive-side checker for a periodic reset pulse train: measures the low and high phase
// lengths of each period, checks them against expected values and flags stuck levels.
module reset_period_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TOL_W       = 8,
    parameter int unsigned PCNT_W      = 16,
    parameter int unsigned STUCK_LIMIT = 32'h0000_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  exp_low_time,
    input  logic [CNT_W-1:0]  exp_high_time,
    input  logic [TOL_W-1:0]  tolerance,
    input  logic              clear,
    output logic [CNT_W-1:0]  meas_low_time,
    output logic [CNT_W-1:0]  meas_high_time,
    output logic              meas_valid,
    output logic              low_err,
    output logic              high_err,
    output logic              stuck,
    output logic [PCNT_W-1:0] period_count
);

    localparam logic [CNT_W-1:0]  Limit   = CNT_W'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0]  LimitM1 = CNT_W'(STUCK_LIMIT - 1);
    localparam logic [PCNT_W-1:0] PcntMax = '1;

    typedef enum logic [1:0] {StAlign, StLow, StHigh} state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic              rise_q, fall_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              low_seen_q, low_seen_d;
    logic [CNT_W-1:0]  meas_low_q, meas_low_d;
    logic [CNT_W-1:0]  meas_high_q, meas_high_d;
    logic              vld_pend_q, vld_pend_d;
    logic              meas_valid_q;
    logic              low_err_q, low_err_d;
    logic              high_err_q, high_err_d;
    logic              stuck_q, stuck_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              edge_act;
    logic              hit_limit;

    function automatic logic out_of_tol(input logic [CNT_W-1:0] meas,
                                        input logic [CNT_W-1:0] expv,
                                        input logic [TOL_W-1:0] tol);
        logic [CNT_W:0] diff;
        if (meas >= expv) diff = {1'b0, meas} - {1'b0, expv};
        else              diff = {1'b0, expv} - {1'b0, meas};
        return diff > (CNT_W+1)'(tol);
    endfunction

    assign edge_act  = rise_q | fall_q;
    // Stuck fires once, on the cycle the counter climbs onto the limit.
    assign hit_limit = !edge_act && (cnt_q == LimitM1);

    always_comb begin
        state_d     = state_q;
        low_seen_d  = low_seen_q;
        meas_low_d  = meas_low_q;
        meas_high_d = meas_high_q;
        vld_pend_d  = 1'b0;
        low_err_d   = clear ? 1'b0 : low_err_q;
        high_err_d  = clear ? 1'b0 : high_err_q;
        stuck_d     = clear ? 1'b0 : stuck_q;
        pcnt_d      = clear ? '0 : pcnt_q;

        if (edge_act)            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (cnt_q != Limit) cnt_d = cnt_q + 1'b1;
        else                     cnt_d = cnt_q;

        case (state_q)
            StAlign: begin
                low_seen_d = 1'b0;
                if (rise_q)      state_d = StHigh;
                else if (fall_q) state_d = StLow;
            end
            StLow: begin
                if (rise_q) begin
                    meas_low_d = cnt_q;
                    if (out_of_tol(cnt_q, exp_low_time, tolerance)) low_err_d = 1'b1;
                    low_seen_d = 1'b1;
                    state_d    = StHigh;
                end
            end
            StHigh: begin
                if (fall_q) begin
                    meas_high_d = cnt_q;
                    if (out_of_tol(cnt_q, exp_high_time, tolerance)) high_err_d = 1'b1;
                    // A high phase entered straight from alignment is not a full period.
                    if (low_seen_q) begin
                        vld_pend_d = 1'b1;
                        if (pcnt_d != PcntMax) pcnt_d = pcnt_d + 1'b1;
                    end
                    state_d = StLow;
                end
            end
            default: state_d = StAlign;
        endcase

        if (hit_limit) begin
            stuck_d = 1'b1;
            state_d = StAlign;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StAlign;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            cnt_q        <= '0;
            low_seen_q   <= 1'b0;
            meas_low_q   <= '0;
            meas_high_q  <= '0;
            vld_pend_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            low_err_q    <= 1'b0;
            high_err_q   <= 1'b0;
            stuck_q      <= 1'b0;
            pcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= pulse_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            rise_q       <= sync2_q & ~sync3_q;
            fall_q       <= ~sync2_q & sync3_q;
            cnt_q        <= cnt_d;
            low_seen_q   <= low_seen_d;
            meas_low_q   <= meas_low_d;
            meas_high_q  <= meas_high_d;
            vld_pend_q   <= vld_pend_d;
            meas_valid_q <= vld_pend_q;
            low_err_q    <= low_err_d;
            high_err_q   <= high_err_d;
            stuck_q      <= stuck_d;
            pcnt_q       <= pcnt_d;
        end
    end

    assign meas_low_time  = meas_low_q;
    assign meas_high_time = meas_high_q;
    assign meas_valid     = meas_valid_q;
    assign low_err        = low_err_q;
    assign high_err       = high_err_q;
    assign stuck          = stuck_q;
    assign period_count   = pcnt_q;

endmodule

// File: tb/tb_reset_period_monitor.sv
// Bench for reset_period_monitor: a phase-level model pushes expected periods into a
// scoreboard that is popped on every meas_valid strobe.
module tb_reset_period_monitor;

    localparam int CNT_W  = 16;
    localparam int TOL_W  = 8;
    localparam int PCNT_W = 16;
    localparam int LIMIT  = 500;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              pulse_in = 1'b0;
    logic [CNT_W-1:0]  exp_low_time = 16'd98;
    logic [CNT_W-1:0]  exp_high_time = 16'd2;
    logic [TOL_W-1:0]  tolerance = 8'd0;
    logic              clear = 1'b0;
    logic [CNT_W-1:0]  meas_low_time;
    logic [CNT_W-1:0]  meas_high_time;
    logic              meas_valid;
    logic              low_err;
    logic              high_err;
    logic              stuck;
    logic [PCNT_W-1:0] period_count;

    reset_period_monitor #(
        .CNT_W      (CNT_W),
        .TOL_W      (TOL_W),
        .PCNT_W     (PCNT_W),
        .STUCK_LIMIT(LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pulse_in      (pulse_in),
        .exp_low_time  (exp_low_time),
        .exp_high_time (exp_high_time),
        .tolerance     (tolerance),
        .clear         (clear),
        .meas_low_time (meas_low_time),
        .meas_high_time(meas_high_time),
        .meas_valid    (meas_valid),
        .low_err       (low_err),
        .high_err      (high_err),
        .stuck         (stuck),
        .period_count  (period_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int low;
        int high;
        bit lerr;
        bit herr;
        int pcnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Phase-level model: 0 align, 1 low, 2 high.
    int m_state = 0;
    bit m_low_seen = 0;
    int m_level = 0;
    int m_len = 0;
    int m_last_low = 0;
    bit m_lerr = 0;
    bit m_herr = 0;
    int m_pcnt = 0;

    function automatic bit oot(int meas, int expv, int tol);
        int d;
        d = (meas > expv) ? meas - expv : expv - meas;
        return d > tol;
    endfunction

    task automatic model_reset();
        m_state = 0; m_low_seen = 0; m_level = 0; m_len = 0;
        m_lerr = 0; m_herr = 0; m_pcnt = 0;
        sb.delete();
    endtask

    task automatic model_edge(int new_level);
        if (m_len >= LIMIT) begin
            m_state = 0;
            m_low_seen = 0;
        end
        if (new_level == 1) begin
            if (m_state == 1) begin
                m_last_low = m_len;
                if (oot(m_len, int'(exp_low_time), int'(tolerance))) m_lerr = 1;
                m_low_seen = 1;
            end
            m_state = 2;
        end else begin
            if (m_state == 2) begin
                if (oot(m_len, int'(exp_high_time), int'(tolerance))) m_herr = 1;
                if (m_low_seen) begin
                    if (m_pcnt < 65535) m_pcnt++;
                    sb.push_back('{m_last_low, m_len, m_lerr, m_herr, m_pcnt});
                end
            end
            m_state = 1;
        end
    endtask

    task automatic drive_level(int lvl, int n);
        if (lvl != m_level) begin
            model_edge(lvl);
            m_len = 0;
            m_level = lvl;
        end
        pulse_in = (lvl != 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        m_len += n;
    endtask

    task automatic pad_low(int lo);
        if (m_level == 1) drive_level(0, lo);
        else if (m_len < lo) drive_level(0, lo - m_len);
    endtask

    task automatic run_train(int periods, int lo, int hi);
        for (int i = 0; i < periods; i++) begin
            pad_low(lo);
            drive_level(1, hi);
            drive_level(0, 6);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            drive_level(m_level, 1);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected periods never reported, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive_level(m_level, 1);
        clear = 1'b0;
        m_lerr = 0; m_herr = 0; m_pcnt = 0;
    endtask

    always @(negedge clk) begin
        if (reset && meas_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: meas_valid=1, required no period pending");
            end else begin
                mon_e = sb.pop_front();
                if (meas_low_time !== 16'(mon_e.low)) begin
                    errors++;
                    $display("FAIL sb_low: got %0d, want %0d", meas_low_time, mon_e.low);
                end
                checks++;
                if (meas_high_time !== 16'(mon_e.high)) begin
                    errors++;
                    $display("FAIL sb_high: got %0d, want %0d", meas_high_time, mon_e.high);
                end
                checks++;
                if (low_err !== mon_e.lerr) begin
                    errors++;
                    $display("FAIL sb_low_err: got %0b, want %0b", low_err, mon_e.lerr);
                end
                checks++;
                if (high_err !== mon_e.herr) begin
                    errors++;
                    $display("FAIL sb_high_err: got %0b, want %0b", high_err, mon_e.herr);
                end
                checks++;
                if (period_count !== 16'(mon_e.pcnt)) begin
                    errors++;
                    $display("FAIL sb_pcount: got %0d, want %0d", period_count, mon_e.pcnt);
                end
            end
        end
    end

    task automatic check_zero(string name);
        checks++;
        if ({meas_low_time, meas_high_time, meas_valid, low_err, high_err, stuck,
             period_count} !== '0) begin
            errors++;
            $display("FAIL %s: low=%0d high=%0d vld=%0b le=%0b he=%0b st=%0b pc=%0d, want all 0",
                     name, meas_low_time, meas_high_time, meas_valid, low_err, high_err,
                     stuck, period_count);
        end
    endtask

    task automatic check_bit(string name, logic got, logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b, want %0b", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_zero("reset_state");
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_nominal();
        exp_low_time = 16'd98; exp_high_time = 16'd2; tolerance = 8'd0;
        run_train(5, 98, 2);
        pad_low(98);
        drive_level(1, 2);
        drive_level(0, 4);
        check_bit("valid_latency_early", meas_valid, 1'b0);
        drive_level(0, 1);
        check_bit("valid_latency_5", meas_valid, 1'b1);
        drive_level(0, 6);
        drain();
        check_bit("nominal_low_err", low_err, 1'b0);
        check_bit("nominal_high_err", high_err, 1'b0);
        checks++;
        if (period_count !== 16'd5) begin
            errors++;
            $display("FAIL nominal_pcount: got %0d, want 5", period_count);
        end
    endtask

    task automatic test_high_tolerance();
        exp_high_time = 16'd5; tolerance = 8'd2;
        run_train(1, 98, 2);
        drain();
        check_bit("tol_high_err_set", high_err, 1'b1);
        check_bit("tol_low_err_clear", low_err, 1'b0);
        do_clear();
        check_bit("clear_high_err", high_err, 1'b0);
        checks++;
        if (period_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_pcount: got %0d, want 0", period_count);
        end
        run_train(1, 98, 2);
        drain();
        check_bit("tol_high_err_reset", high_err, 1'b1);
        exp_high_time = 16'd2; tolerance = 8'd0;
        do_clear();
    endtask

    task automatic test_stuck_high();
        pad_low(98);
        drive_level(1, LIMIT + 2);
        check_bit("stuck_high_early", stuck, 1'b0);
        drive_level(1, 1);
        check_bit("stuck_high_set", stuck, 1'b1);
        drive_level(1, 50);
        run_train(3, 98, 2);
        drain();
        check_bit("stuck_sticky", stuck, 1'b1);
        check_bit("stuck_no_err", low_err | high_err, 1'b0);
    endtask

    task automatic test_stuck_low();
        int pc;
        do_clear();
        check_bit("stuck_cleared", stuck, 1'b0);
        run_train(2, 98, 2);
        drain();
        pc = m_pcnt;
        drive_level(0, LIMIT + 20);
        check_bit("stuck_low_set", stuck, 1'b1);
        checks++;
        if (period_count !== 16'(pc)) begin
            errors++;
            $display("FAIL stuck_low_pcount: got %0d, want %0d", period_count, pc);
        end
    endtask

    task automatic test_reset_mid_phase();
        run_train(2, 98, 2);
        drain();
        drive_level(0, 20);
        reset = 1'b0;
        #1;
        check_zero("reset_mid_low");
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check_zero("reset_held");
        reset = 1'b1;
        model_reset();
        run_train(3, 98, 2);
        drain();
        checks++;
        if (period_count !== 16'd2) begin
            errors++;
            $display("FAIL reset_recover_pcount: got %0d, want 2", period_count);
        end
    endtask

    task automatic test_exp_change();
        exp_low_time = 16'd98; tolerance = 8'd3;
        run_train(2, 98, 2);
        drain();
        check_bit("exp_change_prior", low_err, 1'b0);
        pad_low(40);
        exp_low_time = 16'd50;
        pad_low(98);
        drive_level(1, 2);
        drive_level(0, 6);
        drain();
        check_bit("exp_change_low_err", low_err, 1'b1);
        check_bit("exp_change_high_err", high_err, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_high_tolerance();
        test_stuck_high();
        test_stuck_low();
        test_reset_mid_phase();
        test_exp_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
